// File: rtl/mccu_pkg.sv
// mccu_pkg: shared constants and types for the multi-cycle control unit.
//   - state_t   : FSM state codes (SIF..SWB), also presented on the debug port
//   - OP_* / F_*: MIPS opcode and function-field constants
//   - ALUC_*    : ALU operation codes
//   - ASB_*     : ALU B-input select codes
//   - PCS_*     : PC source select codes
//   - dec_t     : one-hot instruction flags plus class bits from mccu_decode
package mccu_pkg;

  typedef enum logic [2:0] {
    SIF  = 3'd0,
    SID  = 3'd1,
    SEXE = 3'd2,
    SMEM = 3'd3,
    SWB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] ASB_REGB = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_RA     = 2'b10;
  localparam logic [1:0] PCS_JUMP   = 2'b11;

  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lui;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_j;
    logic i_jal;
    logic rtype;      // R-format ALU ops (jr excluded)
    logic itype_alu;
    logic mem;
    logic branch;
    logic jump;       // j, jal, jr
    logic valid;      // any recognised instruction
  } dec_t;

endpackage

// File: rtl/mccu_fsm_decode.sv
// mccu_decode: combinational instruction decoder.
//   in  op[5:0], func[5:0] : instruction[31:26] and instruction[5:0]
//   out dec                : one-hot instruction flags and class bits
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  logic r;

  always_comb begin
    dec = '0;
    r   = (op == OP_RTYPE);

    dec.i_add  = r && (func == F_ADD);
    dec.i_sub  = r && (func == F_SUB);
    dec.i_and  = r && (func == F_AND);
    dec.i_or   = r && (func == F_OR);
    dec.i_xor  = r && (func == F_XOR);
    dec.i_sll  = r && (func == F_SLL);
    dec.i_srl  = r && (func == F_SRL);
    dec.i_sra  = r && (func == F_SRA);
    dec.i_jr   = r && (func == F_JR);
    dec.i_addi = (op == OP_ADDI);
    dec.i_andi = (op == OP_ANDI);
    dec.i_ori  = (op == OP_ORI);
    dec.i_xori = (op == OP_XORI);
    dec.i_lui  = (op == OP_LUI);
    dec.i_lw   = (op == OP_LW);
    dec.i_sw   = (op == OP_SW);
    dec.i_beq  = (op == OP_BEQ);
    dec.i_bne  = (op == OP_BNE);
    dec.i_j    = (op == OP_J);
    dec.i_jal  = (op == OP_JAL);

    dec.rtype     = dec.i_add | dec.i_sub | dec.i_and | dec.i_or | dec.i_xor |
                    dec.i_sll | dec.i_srl | dec.i_sra;
    dec.itype_alu = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui;
    dec.mem       = dec.i_lw | dec.i_sw;
    dec.branch    = dec.i_beq | dec.i_bne;
    dec.jump      = dec.i_j | dec.i_jal | dec.i_jr;
    dec.valid     = dec.rtype | dec.itype_alu | dec.mem | dec.branch | dec.jump;
  end

endmodule

// File: rtl/mccu_fsm.sv
// mccu_fsm: multi-cycle MIPS control unit (IF/ID/EXE/MEM/WB sequencer).
//   in  clk, reset (async, active-high -> SIF), op, func, z (ALU zero flag)
//   out wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
//       alusrcb[1:0], aluc[3:0], pcsource[1:0], state[2:0] (debug),
//       instret[31:0] (retired-instruction count)
// Optional: define MCCU_PERF_CNT_EN to build the instret counter; otherwise
// instret is held at zero and no counter flops exist.
// All outputs decode combinationally from the state register, so reset forces
// the SIF output set immediately without waiting for a clock edge.
module mccu_fsm
  import mccu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        z,
  output logic        wpc,
  output logic        wir,
  output logic        wmem,
  output logic        wreg,
  output logic        iord,
  output logic        regrt,
  output logic        m2reg,
  output logic        jal,
  output logic        shift,
  output logic        sext,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [3:0]  aluc,
  output logic [1:0]  pcsource,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t state_q, state_d;
  dec_t   dec;

  mccu_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SIF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d  = SIF;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ASB_REGB;
    aluc     = ALUC_ADD;
    pcsource = PCS_ALU;

    unique case (state_q)
      SIF: begin
        wpc     = 1'b1;
        wir     = 1'b1;
        alusrcb = ASB_FOUR;
        state_d = SID;
      end

      SID: begin
        // ALU computes PC+4 + (sext(imm)<<2) here so a taken branch can
        // load the ALU-out register in SEXE.
        alusrcb = ASB_IMM2;
        sext    = 1'b1;
        if (dec.i_jal) begin
          wpc      = 1'b1;
          pcsource = PCS_JUMP;
          wreg     = 1'b1;
          jal      = 1'b1;
        end else if (dec.i_j) begin
          wpc      = 1'b1;
          pcsource = PCS_JUMP;
        end else if (dec.i_jr) begin
          wpc      = 1'b1;
          pcsource = PCS_RA;
        end
        // Undecoded instructions fall through as a two-cycle NOP.
        state_d = (dec.valid && !dec.jump) ? SEXE : SIF;
      end

      SEXE: begin
        if (dec.branch) begin
          alusrca = 1'b1;
          aluc    = ALUC_SUB;
          if ((dec.i_beq && z) || (dec.i_bne && !z)) begin
            wpc      = 1'b1;
            pcsource = PCS_ALUOUT;
          end
          state_d = SIF;
        end else if (dec.mem) begin
          alusrca = 1'b1;
          alusrcb = ASB_IMM;
          sext    = 1'b1;
          state_d = SMEM;
        end else if (dec.rtype) begin
          alusrca = 1'b1;
          shift   = dec.i_sll | dec.i_srl | dec.i_sra;
          if      (dec.i_sub) aluc = ALUC_SUB;
          else if (dec.i_and) aluc = ALUC_AND;
          else if (dec.i_or)  aluc = ALUC_OR;
          else if (dec.i_xor) aluc = ALUC_XOR;
          else if (dec.i_sll) aluc = ALUC_SLL;
          else if (dec.i_srl) aluc = ALUC_SRL;
          else if (dec.i_sra) aluc = ALUC_SRA;
          state_d = SWB;
        end else if (dec.itype_alu) begin
          alusrcb = ASB_IMM;
          sext    = dec.i_addi;
          if      (dec.i_andi) aluc = ALUC_AND;
          else if (dec.i_ori)  aluc = ALUC_OR;
          else if (dec.i_xori) aluc = ALUC_XOR;
          else if (dec.i_lui)  aluc = ALUC_LUI;
          state_d = SWB;
        end
      end

      SMEM: begin
        iord    = 1'b1;
        wmem    = dec.i_sw;
        state_d = dec.i_lw ? SWB : SIF;
      end

      SWB: begin
        wreg    = 1'b1;
        m2reg   = dec.i_lw;
        regrt   = dec.i_lw | dec.itype_alu;
        state_d = SIF;
      end

      default: state_d = SIF;
    endcase
  end

`ifdef MCCU_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if ((state_q != SIF) && (state_d == SIF)) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
